// File: rtl/icache_sa_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Latency: n/a (types, constants and address-field helpers only).
// Backpressure: n/a.
package icache_sa_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESP  = 3'd1,
        ST_AR    = 3'd2,
        ST_RFILL = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    // AXI response and burst encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Tag width left over after the byte, word-offset and set-index fields
    function automatic int tag_width(input int sets_dig, input int words_dig);
        return 30 - sets_dig - words_dig;
    endfunction

endpackage

// File: rtl/icache_sa_way.sv
// One way of the cache: valid bits, tags and line data for every set.
// Latency: lookup is combinational; writes land on the next clk edge.
// Backpressure: none, writes are accepted every cycle they are enabled.
module icache_sa_way
    import icache_sa_pkg::*;
#(
    parameter int SETS_DIG  = 2,
    parameter int WORDS_DIG = 2,
    parameter int TAG_W     = tag_width(SETS_DIG, WORDS_DIG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    // lookup port
    input  logic [SETS_DIG-1:0]  lk_set,
    input  logic [WORDS_DIG-1:0] lk_off,
    input  logic [TAG_W-1:0]     lk_tag,
    output logic                 lk_hit,
    output logic                 lk_vld,
    output logic [31:0]          lk_dat,
    // refill port
    input  logic [SETS_DIG-1:0]  wr_set,
    input  logic                 wr_en,
    input  logic [WORDS_DIG-1:0] wr_off,
    input  logic [31:0]          wr_dat,
    input  logic                 tag_we,
    input  logic [TAG_W-1:0]     tag_dat,
    input  logic                 vld_dat
);

    localparam int SETS  = 1 << SETS_DIG;
    localparam int WORDS = 1 << WORDS_DIG;

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [TAG_W-1:0] tag_d  [SETS];
    logic [31:0]      data_q [SETS*WORDS];
    logic [31:0]      data_d [SETS*WORDS];

    // Lookup: a way hits when the indexed set is valid and its tag matches
    always_comb begin
        lk_vld = valid_q[lk_set];
        lk_hit = lk_vld && (tag_q[lk_set] == lk_tag);
        lk_dat = data_q[{lk_set, lk_off}];
    end

    // Next-state of the arrays: beat writes, tag/valid install, flush clears valids
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[{wr_set, wr_off}] = wr_dat;
        end
        if (tag_we) begin
            tag_d[wr_set]   = tag_dat;
            valid_d[wr_set] = vld_dat;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Valid bits are the only array state that needs reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage, meaningless while the valid bit is clear
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative I-cache between IFU and an AXI4 read bus; optional ICACHE_EARLY_RESTART_EN.
// Latency: hits respond in the request cycle; misses take AR + bus latency + one line burst + RESP.
// Backpressure: ifu_arready only in IDLE without pending flush; RESP holds word until ifu_rready.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int WAYS_DIG  = 1,
    parameter int SETS_DIG  = 2,
    parameter int WORDS_DIG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] out_araddr,
    output logic        out_arvalid,
    input  logic        out_arready,
    output logic [7:0]  out_arlen,
    output logic [1:0]  out_arburst,
    input  logic [31:0] out_rdata,
    input  logic [1:0]  out_rresp,
    input  logic        out_rvalid,
    output logic        out_rready,
    input  logic        out_rlast,
    input  logic        fence_i
);

    localparam int WAYS  = 1 << WAYS_DIG;
    localparam int SETS  = 1 << SETS_DIG;
    localparam int WORDS = 1 << WORDS_DIG;
    localparam int TAG_W = tag_width(SETS_DIG, WORDS_DIG);
    // Way-index width; kept at one bit for the direct-mapped case and pinned to zero there
    localparam int VIC_W = (WAYS_DIG > 0) ? WAYS_DIG : 1;

    // Registered state
    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [VIC_W-1:0]     victim_q, victim_d;
    logic                 vic_vld_q, vic_vld_d;
    logic [WORDS_DIG-1:0] beat_cnt_q, beat_cnt_d;
    logic                 err_q, err_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 served_q, served_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [VIC_W-1:0]     ptr_q [SETS];
    logic [VIC_W-1:0]     ptr_d [SETS];

    // Address fields of the incoming request and of the latched miss
    logic [TAG_W-1:0]     lk_tag, miss_tag;
    logic [SETS_DIG-1:0]  lk_set, miss_set;
    logic [WORDS_DIG-1:0] lk_off, miss_off;
    logic [3:0]           unused_addr_bits;

    assign lk_tag   = ifu_araddr[31 -: TAG_W];
    assign lk_set   = ifu_araddr[WORDS_DIG+2 +: SETS_DIG];
    assign lk_off   = ifu_araddr[2 +: WORDS_DIG];
    assign miss_tag = addr_q[31 -: TAG_W];
    assign miss_set = addr_q[WORDS_DIG+2 +: SETS_DIG];
    assign miss_off = addr_q[2 +: WORDS_DIG];
    assign unused_addr_bits = {ifu_araddr[1:0], addr_q[1:0]};

    // Way array interface
    logic [WAYS-1:0] hit_vec, vld_vec;
    logic [31:0]     way_dat [WAYS];
    logic            refill_we, tag_we, tag_vld, flush_all;
    logic            hit;
    logic [31:0]     hit_dat;
    logic [VIC_W-1:0] victim_c;
    logic            beat_err, err_now, er_crit;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_sa_way #(
            .SETS_DIG  (SETS_DIG),
            .WORDS_DIG (WORDS_DIG),
            .TAG_W     (TAG_W)
        ) u_way (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush_all),
            .lk_set  (lk_set),
            .lk_off  (lk_off),
            .lk_tag  (lk_tag),
            .lk_hit  (hit_vec[w]),
            .lk_vld  (vld_vec[w]),
            .lk_dat  (way_dat[w]),
            .wr_set  (miss_set),
            .wr_en   (refill_we && (victim_q == VIC_W'(w))),
            .wr_off  (beat_cnt_q),
            .wr_dat  (out_rdata),
            .tag_we  (tag_we && (victim_q == VIC_W'(w))),
            .tag_dat (miss_tag),
            .vld_dat (tag_vld)
        );
    end

    // Hit merge and victim choice: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        hit      = |hit_vec;
        hit_dat  = '0;
        victim_c = ptr_q[lk_set];
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_dat = hit_dat | way_dat[w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_vec[w]) begin
                victim_c = VIC_W'(w);
            end
        end
    end

    assign beat_err = out_rvalid && (out_rresp != RESP_OKAY);
    assign err_now  = err_q || beat_err;

`ifdef ICACHE_EARLY_RESTART_EN
    // Critical beat forwarded straight to the IFU, at most once per refill
    assign er_crit = (state_q == ST_RFILL) && out_rvalid && (beat_cnt_q == miss_off) && !served_q;
`else
    assign er_crit = 1'b0;
`endif

    // Controller next-state: lookup, refill sequencing, response hold and flush
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        victim_d     = victim_q;
        vic_vld_d    = vic_vld_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        flush_pend_d = flush_pend_q;
        served_d     = served_q;
        rdata_d      = rdata_q;
        ptr_d        = ptr_q;
        refill_we    = 1'b0;
        tag_we       = 1'b0;
        tag_vld      = 1'b0;
        flush_all    = 1'b0;

        // A fence while busy is remembered and serviced once back in IDLE
        if (fence_i && (state_q == ST_RESP || state_q == ST_AR || state_q == ST_RFILL)) begin
            flush_pend_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fence_i || flush_pend_q) begin
                    state_d = ST_FLUSH;
                end else if (ifu_arvalid) begin
                    if (hit) begin
                        if (!ifu_rready) begin
                            rdata_d = hit_dat;
                            state_d = ST_RESP;
                        end
                    end else begin
                        addr_d     = ifu_araddr;
                        victim_d   = victim_c;
                        vic_vld_d  = &vld_vec;
                        beat_cnt_d = '0;
                        err_d      = 1'b0;
                        served_d   = 1'b0;
                        state_d    = ST_AR;
                    end
                end
            end
            ST_AR: begin
                if (out_arready) begin
                    state_d = ST_RFILL;
                end
            end
            ST_RFILL: begin
                if (out_rvalid) begin
                    refill_we  = 1'b1;
                    err_d      = err_now;
                    beat_cnt_d = beat_cnt_q + WORDS_DIG'(1);
                    if (beat_cnt_q == miss_off) begin
                        rdata_d = out_rdata;
                    end
                    if (er_crit && ifu_rready) begin
                        served_d = 1'b1;
                    end
                    if (out_rlast) begin
                        tag_we  = 1'b1;
                        tag_vld = !err_now;
                        // Pointer moves only when a live line was displaced
                        if (WAYS_DIG > 0 && vic_vld_q) begin
                            ptr_d[miss_set] = victim_q + VIC_W'(1);
                        end
                        if (served_q || (er_crit && ifu_rready)) begin
                            err_d   = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (ifu_rready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush_all    = 1'b1;
                flush_pend_d = 1'b0;
                for (int s = 0; s < SETS; s++) begin
                    ptr_d[s] = '0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            served_q     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            flush_pend_q <= flush_pend_d;
            served_q     <= served_d;
            ptr_q        <= ptr_d;
        end
    end

    // Datapath registers, only meaningful once the FSM has loaded them
    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        victim_q  <= victim_d;
        vic_vld_q <= vic_vld_d;
        rdata_q   <= rdata_d;
    end

    // Output decode; reset forces the idle handshake values
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = RESP_OKAY;
        out_arvalid = 1'b0;
        out_rready  = 1'b0;
        if (rst) begin
            ifu_arready = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    ifu_arready = !fence_i && !flush_pend_q;
                    if (ifu_arvalid && hit && !fence_i && !flush_pend_q) begin
                        ifu_rvalid = 1'b1;
                        ifu_rdata  = hit_dat;
                    end
                end
                ST_AR: begin
                    out_arvalid = 1'b1;
                end
                ST_RFILL: begin
                    out_rready = 1'b1;
                    if (er_crit) begin
                        ifu_rvalid = 1'b1;
                        ifu_rdata  = out_rdata;
                        ifu_rresp  = err_now ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                ST_RESP: begin
                    ifu_rvalid = 1'b1;
                    ifu_rdata  = rdata_q;
                    ifu_rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_araddr  = {addr_q[31:WORDS_DIG+2], {(WORDS_DIG+2){1'b0}}};
    assign out_arlen   = 8'(WORDS - 1);
    assign out_arburst = BURST_INCR;

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised N-way set-associative instruction cache between the IFU and the AXI4 memory bus. It generalises the direct-mapped ICACHE with configurable ways, sets and line size, and adds round-robin replacement, bus-error propagation and fence.i flushing. Hits return in the request cycle; misses refill a whole line with one INCR burst.

## Interface
- WAYS_DIG, 1 — log2 of ways per set (0 = direct-mapped).
- SETS_DIG, 2 — log2 of sets.
- WORDS_DIG, 2 — log2 of 32-bit words per line (1..3; burst length 2..8).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifu_araddr  in  32  fetch address; bits [1:0] ignored.
- ifu_arvalid  in  1  fetch request.
- ifu_arready  out  1  high in IDLE with no pending flush.
- ifu_rdata  out  32  instruction word.
- ifu_rresp  out  2  OKAY (00), or SLVERR (10) after a failed refill.
- ifu_rvalid  out  1  response valid.
- ifu_rready  in  1  IFU accepts the response.
- out_araddr  out  32  line-aligned refill address.
- out_arvalid  out  1  refill request.
- out_arready  in  1  bus accepts the address.
- out_arlen  out  8  constant 2^WORDS_DIG−1.
- out_arburst  out  2  constant 01 (INCR).
- out_rdata  in  32  refill beat.
- out_rresp  in  2  beat response.
- out_rvalid  in  1  beat valid.
- out_rready  out  1  high in RFILL.
- out_rlast  in  1  final beat.
- fence_i  in  1  invalidate-all request (single-cycle pulse).

## Operation
- Address split: tag = [31:2+WORDS_DIG+SETS_DIG], set index = [SETS_DIG+WORDS_DIG+1:WORDS_DIG+2], word offset = [WORDS_DIG+1:2].
- Storage per set and way: valid bit, tag, and 2^WORDS_DIG data words. Each set also has a WAYS_DIG-bit round-robin pointer.
- States: IDLE, RESP, AR, RFILL, FLUSH.
- **IDLE.**
  - Flush has priority: if fence_i or flush_pend is set, go to FLUSH and assert no ifu_arready.
  - Otherwise, on ifu_arvalid, look up all ways. On a hit (exactly one way may match), drive ifu_rvalid=1 and the hit word combinationally.
  - If ifu_rready is also high, stay in IDLE; otherwise latch the word and go to RESP.
  - On a miss, latch the address and choose a victim: the lowest-index invalid way, or the pointer way if all ways are valid. Then go to AR.
- **AR.** Hold out_arvalid high. Go to RFILL on out_arready.
- **RFILL.**
  - Each beat writes the victim line word at beat_cnt, then increments beat_cnt.
  - The beat with beat_cnt == offset is latched as the response word.
  - If any beat's out_rresp is not OKAY, set a sticky err bit.
  - On out_rlast, write the tag. Set valid only if err is clear; if err is set, leave the way invalid. Advance the set's pointer only when a valid line was replaced. Then go to RESP.
- **RESP.** Hold ifu_rvalid=1 with ifu_rresp = err ? SLVERR : OKAY. On ifu_rready, clear err and return to IDLE.
- **FLUSH.** Clear every valid bit and every pointer in one cycle, clear flush_pend, return to IDLE.
- fence_i pulses that arrive in RESP, AR or RFILL set flush_pend. The refill in progress still completes and its line is installed, then flushed.
- Replacement pointer width is 0 when WAYS_DIG=0; the victim is then always way 0.

## Timing
- Reset: state=IDLE; all valid bits, pointers, err and flush_pend = 0.
- Output values during reset: ifu_arready=1, ifu_rvalid=0, out_arvalid=0, out_rready=0, ifu_rresp=00, ifu_rdata=0.
- Hit latency: 0 cycles (rvalid in the same cycle as arvalid).
- Miss latency: one cycle to AR, plus bus latency, plus 2^WORDS_DIG beats, plus one cycle in RESP.
- out_araddr is stable while out_arvalid is high. ifu_rdata is stable while in RESP.
- If rst is asserted mid-refill, the cache aborts to IDLE with all lines invalid. Remaining bus beats are not accepted.
- fence_i arriving in the same cycle as a hit request: the flush wins and the request is not accepted (arready=0).

## Configuration
- ICACHE_EARLY_RESTART_EN defined: ifu_rvalid is also asserted in RFILL, in the cycle the critical beat arrives, with ifu_rdata=out_rdata.
  - If the IFU takes that beat, no RESP cycle follows the refill; the FSM returns directly to IDLE after rlast.
  - If the IFU does not take it, the word is latched and the normal RESP path applies.
  - ifu_arready stays low until the refill completes.
- Undefined: the response is given only in RESP, after rlast.

## Structure
- Shared package: state encoding, OKAY/SLVERR constants, and the address-field widths derived from the three parameters.
- One natural sub-module, icache_sa_way: the tag/valid/data array for a single way, with a lookup port and a refill write port. It is instantiated WAYS times via generate.

## Test plan
- **Cold miss then hit.** WAYS_DIG=1, SETS_DIG=2, WORDS_DIG=2. Fetch 0x8000_0004 → one AR to 0x8000_0000 with arlen=3, four beats, returns beat 1. Fetch 0x8000_0008 next → same-cycle hit with beat 2.
- **Conflict and replacement.** Fill 0x8000_0000 and 0x8000_0040 (same set) → both later hit. Fetch 0x8000_0080 → evicts way 0. A refetch of 0x8000_0000 then misses.
- **Bus error.** Beat 2 returns SLVERR → ifu_rresp=10. A refetch of the same line misses again.
- **fence.i during refill.** fence_i pulses at beat 1 → the response completes, FLUSH follows, and the next fetch of the same line misses.
- **IFU backpressure.** Hold ifu_rready=0 for 5 cycles after a hit → rvalid and rdata stay stable in RESP.
- **Early restart (macro on).** Offset-0 miss → rvalid in the same cycle as beat 0, and no RESP cycle after rlast.
